// File: rtl/buart_pkg.sv
// Shared constants for the buffered UART: parity modes, FSM encodings and
// the frame-length helper used to size the shifters and bit counters.
package buart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // TX FSM encoding
  localparam logic TX_IDLE  = 1'b0;
  localparam logic TX_SHIFT = 1'b1;

  // RX FSM encoding
  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  // Total bits on the wire: start + payload + optional parity + stop bits.
  function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/buart_sfifo.sv
// Synchronous FIFO with first-word fall-through head. A push into a full
// FIFO lands only if a pop happens in the same cycle; a pop on empty is ignored.
module buart_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (level == '0);
  assign full    = (level == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  // Storage write; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // Pointers wrap naturally (DEPTH is a power of 2); level tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/buart_fifo.sv
// Buffered UART: configurable frame, TX/RX FIFOs, start-bit glitch rejection,
// per-word framing/parity flags and a sticky overrun flag.
// Bus side: wr and rd are single-cycle strobes sampled on the rising clock;
// wr is accepted when the TX FIFO has room (or is popped the same cycle),
// rd is accepted when valid=1; there is no back-pressure beyond tx_full/valid.
module buart_fifo
  import buart_pkg::*;
#(
  parameter int FREQ_HZ    = 6000000,
  parameter int BAUDS      = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        resetq,
  input  logic                        rx_raw,
  output logic                        tx,
  input  logic                        wr,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        rd,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_ferr,
  output logic                        rx_perr,
  output logic                        valid,
  output logic                        tx_full,
  output logic                        busy,
  output logic                        overrun,
  input  logic                        clr_ovr,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic [$clog2(FIFO_DEPTH):0] tx_level
);

  localparam int DIV  = FREQ_HZ / BAUDS;
  localparam int FLEN = frame_len(DATA_BITS, PARITY, STOP_BITS);
  localparam int CW   = $clog2(DIV) + 1;
  localparam int IW   = $clog2(FLEN);

  localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);

  // ---------------- reset: async assert, sync deassert ----------------
  logic [1:0] rst_sync;
  logic       rst_n;

  // Release of the internal reset is retimed to clk.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // ---------------- TX path ----------------
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_empty;
  logic                 tx_pop;
  logic                 tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [FLEN-1:0]      tx_sh;
  logic [FLEN-1:0]      tx_frame;
  logic                 tx_bit_end;
  logic                 tx_last;

  buart_sfifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  // Build the complete wire frame (LSB transmitted first) from the FIFO head.
  always_comb begin
    tx_frame                = '1;
    tx_frame[0]             = 1'b0;
    tx_frame[DATA_BITS:1]   = tx_head;
    if (PARITY == PARITY_ODD)       tx_frame[DATA_BITS+1] = ~^tx_head;
    else if (PARITY == PARITY_EVEN) tx_frame[DATA_BITS+1] = ^tx_head;
  end

  assign tx_bit_end = (tx_state == TX_SHIFT) && (tx_cnt == '0);
  assign tx_last    = (tx_idx == IW'(FLEN - 1));
  // Pop from idle, or straight out of the last stop bit for gap-free frames.
  assign tx_pop     = !tx_empty && ((tx_state == TX_IDLE) || (tx_bit_end && tx_last));
  assign busy       = !tx_empty || (tx_state == TX_SHIFT);

  // TX shifter: each bit is held DIV clocks; start bit goes out the cycle after the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '1;
      tx       <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TX_SHIFT;
      tx       <= tx_frame[0];
      tx_sh    <= {1'b1, tx_frame[FLEN-1:1]};
      tx_cnt   <= BIT_RELOAD;
      tx_idx   <= '0;
    end else if (tx_state == TX_SHIFT) begin
      if (tx_cnt == '0) begin
        if (tx_last) begin
          tx_state <= TX_IDLE;
          tx       <= 1'b1;
        end else begin
          tx     <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[FLEN-1:1]};
          tx_idx <= tx_idx + 1'b1;
          tx_cnt <= BIT_RELOAD;
        end
      end else begin
        tx_cnt <= tx_cnt - 1'b1;
      end
    end
  end

  // ---------------- RX path ----------------
  logic [1:0]             rx_sync;
  logic                   rx_s;
  logic [2:0]             rx_state;
  logic [CW-1:0]          rx_cnt;
  logic [IW-1:0]          rx_idx;
  logic [DATA_BITS-1:0]   rx_sh;
  logic                   rx_perr_r;
  logic                   rx_push;
  logic [DATA_BITS+1:0]   rx_word;
  logic [DATA_BITS+1:0]   rx_head;
  logic                   rx_empty;
  logic                   rx_full;
  logic                   ovr_set;

  // Two-flop synchroniser, idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rx_raw};
  end
  assign rx_s = rx_sync[1];

  // RX deframer: sample at mid-bit, reject short start pulses, push on first stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_sh     <= '0;
      rx_perr_r <= 1'b0;
      rx_push   <= 1'b0;
      rx_word   <= '0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_RELOAD;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_s) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= BIT_RELOAD;
              rx_idx   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_s, rx_sh[DATA_BITS-1:1]};
            rx_cnt <= BIT_RELOAD;
            if (rx_idx == IW'(DATA_BITS - 1)) begin
              rx_perr_r <= 1'b0;
              rx_state  <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_cnt == '0) begin
            if (PARITY == PARITY_ODD) rx_perr_r <= ~(^{rx_sh, rx_s});
            else                      rx_perr_r <= ^{rx_sh, rx_s};
            rx_state <= RX_STOP;
            rx_cnt   <= BIT_RELOAD;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            rx_push  <= 1'b1;
            rx_word  <= {rx_perr_r, !rx_s, rx_sh};
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  buart_sfifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_word),
    .pop       (rd),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  assign {rx_perr, rx_ferr, rx_data} = rx_head;
  assign valid   = !rx_empty;
  // A word is lost only when the FIFO is full and no pop frees a slot this cycle.
  assign ovr_set = rx_push && rx_full && !(rd && valid);

  // Sticky overrun; a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_buart_fifo.sv
// Bench for buart_fifo: an 8N1 instance (u_n) and an 8E1 instance (u_e),
// DIV = 1200/100 = 12 clocks per bit.
module tb_buart_fifo;

  localparam int DIV = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetq = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       rx_n = 1'b1, wr_n = 1'b0, rd_n = 1'b0, clr_n = 1'b0;
  logic [7:0] txd_n = 8'h00;
  logic       tx_n, ferr_n, perr_n, valid_n, full_n, busy_n, ovr_n;
  logic [7:0] rxd_n;
  logic [4:0] rxl_n, txl_n;

  logic       rx_e = 1'b1, wr_e = 1'b0, rd_e = 1'b0, clr_e = 1'b0;
  logic [7:0] txd_e = 8'h00;
  logic       tx_e, ferr_e, perr_e, valid_e, full_e, busy_e, ovr_e;
  logic [7:0] rxd_e;
  logic [4:0] rxl_e, txl_e;

  buart_fifo #(.FREQ_HZ(1200), .BAUDS(100), .DATA_BITS(8), .PARITY(0),
               .STOP_BITS(1), .FIFO_DEPTH(16)) u_n (
    .clk(clk), .resetq(resetq), .rx_raw(rx_n), .tx(tx_n), .wr(wr_n), .tx_data(txd_n),
    .rd(rd_n), .rx_data(rxd_n), .rx_ferr(ferr_n), .rx_perr(perr_n), .valid(valid_n),
    .tx_full(full_n), .busy(busy_n), .overrun(ovr_n), .clr_ovr(clr_n),
    .rx_level(rxl_n), .tx_level(txl_n)
  );

  buart_fifo #(.FREQ_HZ(1200), .BAUDS(100), .DATA_BITS(8), .PARITY(2),
               .STOP_BITS(1), .FIFO_DEPTH(16)) u_e (
    .clk(clk), .resetq(resetq), .rx_raw(rx_e), .tx(tx_e), .wr(wr_e), .tx_data(txd_e),
    .rd(rd_e), .rx_data(rxd_e), .rx_ferr(ferr_e), .rx_perr(perr_e), .valid(valid_e),
    .tx_full(full_e), .busy(busy_e), .overrun(ovr_e), .clr_ovr(clr_e),
    .rx_level(rxl_e), .tx_level(txl_e)
  );

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];     // RX words {perr, ferr, data}
  logic [7:0] tx_exp_q[$];  // TX bytes expected on the tx line

  typedef struct {
    logic       use_e;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rx(input logic use_e, input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] bits;
    int          nb;
    if (use_e) begin
      bits = {stop, par, d, 1'b0};
      nb   = 11;
    end else begin
      bits = {1'b1, stop, d, 1'b0};
      nb   = 10;
    end
    for (int i = 0; i < nb; i++) begin
      if (use_e) rx_e = bits[i];
      else       rx_n = bits[i];
      tick(DIV);
    end
    rx_e = 1'b1;
    rx_n = 1'b1;
  endtask

  task automatic do_rd(input logic use_e);
    if (use_e) rd_e = 1'b1;
    else       rd_n = 1'b1;
    tick(1);
    rd_e = 1'b0;
    rd_n = 1'b0;
  endtask

  task automatic wait_valid(input logic use_e);
    int w;
    w = 0;
    while (((use_e ? valid_e : valid_n) !== 1'b1) && w < 200) begin
      tick(1);
      w++;
    end
    check("rx_valid_wait", {31'd0, (use_e ? valid_e : valid_n)}, 32'd1);
  endtask

  task automatic rx_compare(input logic use_e, input string name);
    logic [9:0] got;
    logic [9:0] exp;
    got = use_e ? {perr_e, ferr_e, rxd_e} : {perr_n, ferr_n, rxd_n};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'bx;
    check(name, {22'd0, got}, {22'd0, exp});
  endtask

  // Decode one frame from tx_n; returns at the end of the stop bit.
  task automatic tx_get(output logic [7:0] d, output logic ok);
    int w;
    w  = 0;
    ok = 1'b1;
    d  = 8'h00;
    while (tx_n !== 1'b0 && w < 300) begin
      tick(1);
      w++;
    end
    if (tx_n !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    tick(DIV / 2);
    if (tx_n !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(DIV);
      d[i] = tx_n;
    end
    tick(DIV);
    if (tx_n !== 1'b1) ok = 1'b0;
    tick(DIV / 2);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    logic [9:0] exp_bits;
    logic       ok;
    logic [7:0] wv;
    logic [7:0] first_w;

    vecs[0] = '{1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1};

    // Reset
    tick(3);
    resetq = 1'b1;
    tick(4);
    check("rst_tx",      {31'd0, tx_n},    32'd1);
    check("rst_valid",   {31'd0, valid_n}, 32'd0);
    check("rst_busy",    {31'd0, busy_n},  32'd0);
    check("rst_full",    {31'd0, full_n},  32'd0);
    check("rst_overrun", {31'd0, ovr_n},   32'd0);
    check("rst_levels",  {22'd0, rxl_n, txl_n}, 32'd0);
    check("rst_e",       {27'd0, tx_e, valid_e, busy_e, full_e, ovr_e}, 32'h10);

    // TX single word 8'hA5: start bit two cycles after the wr strobe
    wr_n  = 1'b1;
    txd_n = 8'hA5;
    tick(1);
    wr_n  = 1'b0;
    check("tx_first_cycle", {30'd0, tx_n, busy_n}, 32'h3);
    check("tx_level_one",   {27'd0, txl_n}, 32'd1);
    tick(1);
    exp_bits = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      for (int c = 0; c < DIV; c++) begin
        if (tx_n !== exp_bits[b]) ok = 1'b0;
        if (busy_n !== 1'b1) ok = 1'b0;
        tick(1);
      end
      check($sformatf("tx_a5_bit%0d", b), {31'd0, ok}, 32'd1);
    end
    check("tx_a5_done", {30'd0, tx_n, busy_n}, 32'h2);

    // TX burst: one frame in flight, then 17 back-to-back writes
    fork
      begin
        wr_n  = 1'b1;
        txd_n = 8'h11;
        tx_exp_q.push_back(8'h11);
        tick(1);
        wr_n = 1'b0;
        tick(3);
        for (int i = 0; i < 17; i++) begin
          if (i == 16) check("tx_full_at_16", {31'd0, full_n}, 32'd1);
          wv    = 8'($urandom_range(0, 255));
          wr_n  = 1'b1;
          txd_n = wv;
          if (i < 16) tx_exp_q.push_back(wv);
          tick(1);
        end
        wr_n = 1'b0;
        check("tx_level_16", {27'd0, txl_n}, 32'd16);
      end
      begin
        logic [7:0] d;
        logic [7:0] e;
        logic       fok;
        for (int f = 0; f < 17; f++) begin
          tx_get(d, fok);
          e = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'bx;
          check("tx_frame_shape", {31'd0, fok}, 32'd1);
          check("tx_burst_data", {24'd0, d}, {24'd0, e});
          if (f < 16) check("tx_gap_free", {31'd0, tx_n}, 32'd0);
        end
      end
    join
    check("tx_burst_idle", {30'd0, tx_n, busy_n}, 32'h2);
    check("tx_burst_lvl",  {27'd0, txl_n}, 32'd0);

    // RX table vectors
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back({vecs[v].exp_perr, vecs[v].exp_ferr, vecs[v].exp_data});
      send_rx(vecs[v].use_e, vecs[v].data, vecs[v].par, vecs[v].stop);
      tick(20);
      wait_valid(vecs[v].use_e);
      rx_compare(vecs[v].use_e, $sformatf("rx_vec%0d", v));
      check("rx_level_one", {27'd0, (vecs[v].use_e ? rxl_e : rxl_n)}, 32'd1);
      do_rd(vecs[v].use_e);
      check("rx_after_rd", {26'd0, (vecs[v].use_e ? valid_e : valid_n),
                            (vecs[v].use_e ? rxl_e : rxl_n)}, 32'd0);
    end

    // Start-bit glitch on idle line: nothing queued
    rx_e = 1'b0;
    tick(4);
    rx_e = 1'b1;
    tick(30);
    check("rx_glitch", {26'd0, valid_e, rxl_e}, 32'd0);

    // Overrun: 17 frames without reading
    first_w = 8'h00;
    for (int i = 0; i < 17; i++) begin
      wv = 8'($urandom_range(0, 255));
      if (i == 0) first_w = wv;
      if (i < 16) exp_q.push_back({2'b00, wv});
      send_rx(1'b0, wv, 1'b0, 1'b1);
      if (i == 15) begin
        tick(20);
        check("ovr_level16_pre", {26'd0, ovr_n, rxl_n}, 32'd16);
      end
    end
    tick(20);
    check("ovr_level16",  {27'd0, rxl_n}, 32'd16);
    check("ovr_set",      {31'd0, ovr_n}, 32'd1);
    check("ovr_head",     {24'd0, rxd_n}, {24'd0, first_w});
    clr_n = 1'b1;
    tick(1);
    clr_n = 1'b0;
    check("ovr_clear",    {31'd0, ovr_n}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("ovr_drain_valid", {31'd0, valid_n}, 32'd1);
      rx_compare(1'b0, "ovr_drain_word");
      do_rd(1'b0);
    end
    check("ovr_drained", {26'd0, valid_n, rxl_n}, 32'd0);

    // Reset in the middle of a TX frame
    wr_n  = 1'b1;
    txd_n = 8'h00;
    tick(1);
    wr_n  = 1'b0;
    tick(1);
    tick(3 * DIV + 5);
    check("tx_low_before_reset", {31'd0, tx_n}, 32'd0);
    resetq = 1'b0;
    #1;
    check("tx_reset_immediate", {30'd0, tx_n, busy_n}, 32'h2);
    tick(3);
    resetq = 1'b1;
    tick(4);
    check("tx_after_reset", {30'd0, tx_n, busy_n}, 32'h2);
    check("lvl_after_reset", {21'd0, valid_n, txl_n, rxl_n}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
